// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the endcomfun execute-stage ALU.
//   opcode_e  - micro-op encoding (12-15 are illegal)
//   flags_t   - 6-bit x86-style flag bundle, bit 0 = CF ... bit 5 = OF
//   parity_even / smul128 / fits64 - helpers used by the compute core
package alu_pkg;

  typedef enum logic [3:0] {
    OP_LEA    = 4'd0,
    OP_CPY    = 4'd1,
    OP_CPY_F  = 4'd2,
    OP_ADD    = 4'd3,
    OP_SUB    = 4'd4,
    OP_AND    = 4'd5,
    OP_OR     = 4'd6,
    OP_XOR    = 4'd7,
    OP_SHL    = 4'd8,
    OP_SHR    = 4'd9,
    OP_IMUL_L = 4'd10,
    OP_IMUL_H = 4'd11
  } opcode_e;

  // Last member lands in bit 0, so the packed layout matches [0]=CF .. [5]=OF.
  typedef struct packed {
    logic of;
    logic sf;
    logic zf;
    logic af;
    logic pf;
    logic cf;
  } flags_t;

  // PF is set when the low byte has an even number of ones.
  function automatic logic parity_even(input logic [7:0] x);
    return ~^x;
  endfunction

  // Full signed 64x64 -> 128 product.
  function automatic logic [127:0] smul128(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] ea;
    logic signed [127:0] eb;
    ea = {{64{a[63]}}, a};
    eb = {{64{b[63]}}, b};
    return ea * eb;
  endfunction

  // A product fits in signed 64 bits when bits [127:63] are all copies of the sign.
  function automatic logic fits64(input logic [127:0] p);
    return (&p[127:63]) | ~(|p[127:63]);
  endfunction

endpackage

// File: rtl/endcomfun_if.sv
// endcomfun_if: micro-op issue bus and result bus of the execute-stage ALU.
//   Handshake: in_valid marks a micro-op to be consumed at the next rising
//   clk; there is no ready because the ALU accepts one op every cycle.
//   out_valid marks out_val/out_flags/out_err as a new result for one cycle;
//   the consumer cannot stall it. When out_valid is low the data fields hold.
//   master - issue side (drives the micro-op, observes the result)
//   slave  - the ALU
interface endcomfun_if;
  logic        in_valid;
  logic [3:0]  opcode;
  logic [63:0] src0_val;
  logic [63:0] src1_val;
  logic [5:0]  src0_flags;
  logic [5:0]  src1_flags;
  logic [1:0]  scale;
  logic [63:0] disp;
  logic        out_valid;
  logic [63:0] out_val;
  logic [5:0]  out_flags;
  logic        out_err;

  modport master (
    output in_valid, opcode, src0_val, src1_val, src0_flags, src1_flags, scale, disp,
    input  out_valid, out_val, out_flags, out_err
  );

  modport slave (
    input  in_valid, opcode, src0_val, src1_val, src0_flags, src1_flags, scale, disp,
    output out_valid, out_val, out_flags, out_err
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational compute for one micro-op.
//   opcode, a, b, f0, f1, scale, disp -> val, flags, err
//   Illegal opcodes give err=1 with val=0 and flags=0.
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  flags_t      f0,
  input  flags_t      f1,
  input  logic [1:0]  scale,
  input  logic [63:0] disp,
  output logic [63:0] val,
  output flags_t      flags,
  output logic        err
);

  opcode_e      op;
  logic [64:0]  sum;
  logic [4:0]   nib_sum;
  logic [63:0]  diff;
  logic [127:0] prod;
  logic         ovf;
  logic [5:0]   cnt;
  logic [5:0]   shl_idx;
  logic         set_zsp;

  assign op      = opcode_e'(opcode);
  assign sum     = {1'b0, a} + {1'b0, b};
  assign nib_sum = {1'b0, a[3:0]} + {1'b0, b[3:0]};
  assign diff    = a - b;
  assign prod    = smul128(a, b);
  assign ovf     = ~fits64(prod);
  assign cnt     = b[5:0];
  // 64 - cnt modulo 64: index of the last bit shifted out by SHL (cnt != 0).
  assign shl_idx = 6'd0 - cnt;

  always_comb begin
    val     = '0;
    flags   = '0;
    err     = 1'b0;
    set_zsp = 1'b0;
    case (op)
      OP_LEA:   val = a + (b << scale) + disp;
      OP_CPY:   val = a;
      OP_CPY_F: begin
        val   = a;
        flags = f1;
      end
      OP_ADD: begin
        val      = sum[63:0];
        flags.cf = sum[64];
        flags.af = nib_sum[4];
        flags.of = (a[63] == b[63]) && (sum[63] != a[63]);
        set_zsp  = 1'b1;
      end
      OP_SUB: begin
        val      = diff;
        flags.cf = a < b;
        flags.af = a[3:0] < b[3:0];
        flags.of = (a[63] != b[63]) && (diff[63] != a[63]);
        set_zsp  = 1'b1;
      end
      OP_AND: begin
        val     = a & b;
        set_zsp = 1'b1;
      end
      OP_OR: begin
        val     = a | b;
        set_zsp = 1'b1;
      end
      OP_XOR: begin
        val     = a ^ b;
        set_zsp = 1'b1;
      end
      OP_SHL: begin
        // Zero count passes the operand and its flags straight through.
        if (cnt == 6'd0) begin
          val   = a;
          flags = f0;
        end else begin
          val      = a << cnt;
          flags.cf = a[shl_idx];
          flags.of = (cnt == 6'd1) && (val[63] ^ a[shl_idx]);
          set_zsp  = 1'b1;
        end
      end
      OP_SHR: begin
        if (cnt == 6'd0) begin
          val   = a;
          flags = f0;
        end else begin
          val      = a >> cnt;
          flags.cf = a[cnt - 6'd1];
          flags.of = (cnt == 6'd1) && a[63];
          set_zsp  = 1'b1;
        end
      end
      OP_IMUL_L: begin
        val      = prod[63:0];
        flags.cf = ovf;
        flags.of = ovf;
      end
      OP_IMUL_H: begin
        val      = prod[127:64];
        flags.cf = ovf;
        flags.of = ovf;
      end
      default: err = 1'b1;
    endcase
    if (set_zsp) begin
      flags.zf = (val == 64'd0);
      flags.sf = val[63];
      flags.pf = parity_even(val[7:0]);
    end
  end

endmodule

// File: rtl/endcomfun.sv
// endcomfun: single-cycle registered integer ALU for the execute stage.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; clears all result outputs
//   bus   - endcomfun_if.slave: micro-op in, registered result out
//   Latency 1, throughput 1 op/cycle, no back-pressure.
module endcomfun
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  endcomfun_if.slave  bus
);

  logic [63:0] core_val;
  flags_t      core_flags;
  logic        core_err;

  logic        out_valid_q;
  logic [63:0] out_val_q;
  logic [5:0]  out_flags_q;
  logic        out_err_q;

  alu_core u_core (
    .opcode (bus.opcode),
    .a      (bus.src0_val),
    .b      (bus.src1_val),
    .f0     (bus.src0_flags),
    .f1     (bus.src1_flags),
    .scale  (bus.scale),
    .disp   (bus.disp),
    .val    (core_val),
    .flags  (core_flags),
    .err    (core_err)
  );

  // Result fields only load on a valid op so they hold across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_val_q   <= '0;
      out_flags_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_val_q   <= core_val;
        out_flags_q <= core_flags;
        out_err_q   <= core_err;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_val   = out_val_q;
  assign bus.out_flags = out_flags_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_endcomfun.sv
// tb_endcomfun: scoreboard bench for endcomfun. The driver pushes the expected
// {err, flags, val} of every issued op; a negedge monitor pops and compares each
// out_valid result and checks that outputs hold on idle cycles.
module tb_endcomfun;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  endcomfun_if bus();

  endcomfun dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [70:0] exp_q[$];
  logic [70:0] mon_exp;
  logic [63:0] last_val   = '0;
  logic [5:0]  last_flags = '0;
  logic        last_err   = 1'b0;

  localparam logic signed [127:0] SMAX = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] SMIN = -SMAX - 128'sd1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works from the arithmetic definitions: wide sums, signed range tests,
  // arithmetic shifts of the operand, rather than bit-level carry logic.
  function automatic logic [70:0] model(input logic [3:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input logic [5:0] f0,
                                        input logic [5:0] f1, input logic [1:0] sc,
                                        input logic [63:0] dp);
    logic [63:0] r;
    logic [63:0] tmp;
    logic [127:0] wide;
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    logic signed [127:0] p;
    logic cf, af, of, zsp, raw, err;
    logic [5:0] fl;
    int cnt;
    r = '0; cf = 0; af = 0; of = 0; zsp = 0; raw = 0; err = 0; fl = '0;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    cnt = int'(b % 64);
    case (op)
      4'd0: begin r = a + b * (64'd1 << sc) + dp; raw = 1; end
      4'd1: begin r = a; raw = 1; end
      4'd2: begin r = a; fl = f1; raw = 1; end
      4'd3: begin
        wide = {64'd0, a} + {64'd0, b};
        r = wide[63:0];
        cf = (wide >> 64) != 0;
        af = (a % 16) + (b % 16) >= 16;
        p = sa + sb;
        of = (p > SMAX) || (p < SMIN);
        zsp = 1;
      end
      4'd4: begin
        r = a - b;
        cf = a < b;
        af = (a % 16) < (b % 16);
        p = sa - sb;
        of = (p > SMAX) || (p < SMIN);
        zsp = 1;
      end
      4'd5: begin r = a & b; zsp = 1; end
      4'd6: begin r = a | b; zsp = 1; end
      4'd7: begin r = a ^ b; zsp = 1; end
      4'd8, 4'd9: begin
        if (cnt == 0) begin
          r = a; fl = f0; raw = 1;
        end else if (op == 4'd8) begin
          r = a << cnt;
          tmp = a >> (64 - cnt);
          cf = tmp[0];
          of = (cnt == 1) ? (r[63] ^ cf) : 1'b0;
          zsp = 1;
        end else begin
          r = a >> cnt;
          tmp = a >> (cnt - 1);
          cf = tmp[0];
          of = (cnt == 1) ? a[63] : 1'b0;
          zsp = 1;
        end
      end
      4'd10, 4'd11: begin
        p = sa * sb;
        r = (op == 4'd10) ? p[63:0] : p[127:64];
        cf = (p > SMAX) || (p < SMIN);
        of = cf;
        raw = 1;
        fl = {of, 4'b0000, cf};
      end
      default: err = 1;
    endcase
    if (zsp) fl = {of, r[63], r == 64'd0, af, ($countones(r[7:0]) % 2) == 0, cf};
    else if (!raw) fl = '0;
    return {err, fl, r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] f0, input logic [5:0] f1, input logic [1:0] sc,
                       input logic [63:0] dp);
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.opcode     = op;
    bus.src0_val   = a;
    bus.src1_val   = b;
    bus.src0_flags = f0;
    bus.src1_flags = f1;
    bus.scale      = sc;
    bus.disp       = dp;
  endtask

  task automatic send_exp(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] f0, input logic [5:0] f1, input logic [1:0] sc,
                          input logic [63:0] dp, input logic [63:0] ev, input logic [5:0] ef,
                          input logic ee);
    drive(op, a, b, f0, f1, sc, dp);
    exp_q.push_back({ee, ef, ev});
  endtask

  task automatic send_rand(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [5:0] f0, input logic [5:0] f1, input logic [1:0] sc,
                           input logic [63:0] dp);
    drive(op, a, b, f0, f1, sc, dp);
    exp_q.push_back(model(op, a, b, f0, f1, sc, dp));
  endtask

  // Idle cycle with garbage on the data fields, which must be ignored.
  task automatic idle();
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.opcode     = 4'($urandom);
    bus.src0_val   = {$urandom, $urandom};
    bus.src1_val   = {$urandom, $urandom};
    bus.src0_flags = 6'($urandom);
    bus.src1_flags = 6'($urandom);
    bus.scale      = 2'($urandom);
    bus.disp       = {$urandom, $urandom};
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got %h expected none", bus.out_val);
        end else begin
          mon_exp = exp_q.pop_front();
          check("result", {1'b0, bus.out_err, bus.out_flags, bus.out_val}, {1'b0, mon_exp});
        end
        last_val   = bus.out_val;
        last_flags = bus.out_flags;
        last_err   = bus.out_err;
      end else begin
        check("idle_hold", {1'b0, bus.out_err, bus.out_flags, bus.out_val},
              {1'b0, last_err, last_flags, last_val});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    bus.in_valid = 1'b0;
    bus.opcode = '0; bus.src0_val = '0; bus.src1_val = '0;
    bus.src0_flags = '0; bus.src1_flags = '0; bus.scale = '0; bus.disp = '0;

    repeat (3) @(posedge clk);
    #1 check("reset_state", {bus.out_valid, bus.out_err, bus.out_flags, bus.out_val}, 72'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Directed cases with hand-derived expectations.
    send_exp(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'h00, 6'h00, 2'd0, 64'd0,
             64'h8000_0000_0000_0000, 6'h36, 1'b0);
    send_exp(OP_SUB, 64'd0, 64'd1, 6'h00, 6'h00, 2'd0, 64'd0, '1, 6'h17, 1'b0);
    send_exp(OP_SUB, 64'd5, 64'd5, 6'h00, 6'h00, 2'd0, 64'd0, 64'd0, 6'h0A, 1'b0);
    send_exp(OP_SHL, 64'h8000_0000_0000_0001, 64'd1, 6'h00, 6'h00, 2'd0, 64'd0,
             64'd2, 6'h21, 1'b0);
    send_exp(OP_SHR, 64'h8000_0000_0000_0001, 64'd1, 6'h00, 6'h00, 2'd0, 64'd0,
             64'h4000_0000_0000_0000, 6'h23, 1'b0);
    send_exp(OP_SHL, 64'h8000_0000_0000_0001, 64'h40, 6'h2A, 6'h15, 2'd0, 64'd0,
             64'h8000_0000_0000_0001, 6'h2A, 1'b0);
    idle();
    send_exp(OP_IMUL_L, '1, '1, 6'h00, 6'h00, 2'd0, 64'd0, 64'd1, 6'h00, 1'b0);
    send_exp(OP_IMUL_H, '1, '1, 6'h00, 6'h00, 2'd0, 64'd0, 64'd0, 6'h00, 1'b0);
    send_exp(OP_IMUL_L, 64'h4000_0000_0000_0000, 64'd4, 6'h00, 6'h00, 2'd0, 64'd0,
             64'd0, 6'h21, 1'b0);
    send_exp(OP_IMUL_H, 64'h4000_0000_0000_0000, 64'd4, 6'h00, 6'h00, 2'd0, 64'd0,
             64'd1, 6'h21, 1'b0);
    send_exp(OP_LEA, 64'h1000, 64'd3, 6'h3F, 6'h3F, 2'd3, 64'hFFFF_FFFF_FFFF_FFF8,
             64'h1010, 6'h00, 1'b0);
    send_exp(OP_CPY_F, 64'h55, 64'd9, 6'h00, 6'h3F, 2'd0, 64'd0, 64'h55, 6'h3F, 1'b0);
    send_exp(OP_CPY, 64'h1234, 64'd9, 6'h3F, 6'h3F, 2'd0, 64'd0, 64'h1234, 6'h00, 1'b0);
    send_exp(4'd13, 64'h1234, 64'd9, 6'h3F, 6'h3F, 2'd0, 64'd0, 64'd0, 6'h00, 1'b1);
    idle();
    idle();

    // Asynchronous reset while a result is showing and another op is in flight.
    send_exp(OP_ADD, 64'd7, 64'd9, 6'h00, 6'h00, 2'd0, 64'd0, 64'd16, 6'h04, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {bus.out_valid, bus.out_err, bus.out_flags, bus.out_val}, 72'd0);
    exp_q.delete();
    @(posedge clk);
    #1 check("reset_discard", {bus.out_valid, bus.out_err, bus.out_flags, bus.out_val}, 72'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    last_val = '0; last_flags = '0; last_err = 1'b0;
    #2 rst_n = 1'b1;
    send_exp(OP_XOR, 64'hFF00, 64'h0FF0, 6'h00, 6'h00, 2'd0, 64'd0, 64'hF0F0, 6'h02, 1'b0);
    idle();

    // Randomized ops against the reference model, with idle gaps.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle();
      end else begin
        op = 4'($urandom_range(0, 15));
        a = rnd64();
        if ((op == OP_SHL || op == OP_SHR) && $urandom_range(0, 1) == 1)
          b = 64'($urandom_range(0, 70));
        else
          b = rnd64();
        send_rand(op, a, b, 6'($urandom), 6'($urandom), 2'($urandom), rnd64());
      end
    end
    idle();
    idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
